// File: rtl/trace_emitter.sv
// trace_emitter: packs retirement events into REG/LOAD/STORE records and sends them through a FIFO to a valid/ready sink.
// Optional feature macro TRACE_STATS_EN: saturating event counters plus a STATS record phase after halt.
module trace_emitter #(
  parameter int unsigned DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_wr,
  input  logic [2:0]  reg_sel,
  input  logic [15:0] reg_data,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_rdata,
  input  logic [15:0] mem_wdata,
  input  logic        halt,
  input  logic        icache_req,
  input  logic        icache_hit,
  input  logic        dcache_req,
  input  logic        dcache_hit,
  output logic        rec_valid,
  input  logic        rec_ready,
  output logic [1:0]  rec_type,
  output logic [15:0] rec_a,
  output logic [15:0] rec_b,
  output logic        trace_full,
  output logic        overflow,
  output logic        done
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [1:0] T_REG   = 2'd0;
  localparam logic [1:0] T_LOAD  = 2'd1;
  localparam logic [1:0] T_STORE = 2'd2;

  typedef struct packed {
    logic [1:0]  rtype;
    logic [15:0] a;
    logic [15:0] b;
  } rec_t;

`ifdef TRACE_STATS_EN
  localparam logic [1:0] T_STAT = 2'd3;
  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_STATS = 2'd2,
    S_DONE  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd3
  } state_t;
`endif

  state_t           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_ptr_p1;
  logic [CNT_W-1:0] count_q, count_d, free_slots, need, n_push;
  logic             overflow_q, overflow_d;
  logic             full_q, full_d;
  logic             push0, push1, pop, head_valid;
  rec_t             reg_rec, mem_rec, rec0, rec1, head;
  rec_t             mem_q [DEPTH];

  // Record builders and FIFO status decode
  always_comb begin
    reg_rec.rtype = T_REG;
    reg_rec.a     = {13'b0, reg_sel};
    reg_rec.b     = reg_data;
    // A simultaneous read and write is traced as a store only
    mem_rec.rtype = mem_wr ? T_STORE : T_LOAD;
    mem_rec.a     = mem_addr;
    mem_rec.b     = mem_wr ? mem_wdata : mem_rdata;
    wr_ptr_p1     = wr_ptr_q + PTR_W'(1);
    head_valid    = (count_q != '0);
    head          = mem_q[rd_ptr_q];
    free_slots    = CNT_W'(DEPTH) - count_q;
    need          = CNT_W'(reg_wr) + CNT_W'(mem_rd | mem_wr);
  end

`ifdef TRACE_STATS_EN
  logic [15:0] cyc_q, cyc_d, inst_q, inst_d;
  logic [15:0] dhit_q, dhit_d, ihit_q, ihit_d;
  logic [15:0] dreq_q, dreq_d, ireq_q, ireq_d;
  logic [2:0]  stat_idx_q, stat_idx_d;
  logic [15:0] stat_val;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

  // Counters advance only while retiring, halt cycle included
  always_comb begin
    cyc_d  = cyc_q;
    inst_d = inst_q;
    dhit_d = dhit_q;
    ihit_d = ihit_q;
    dreq_d = dreq_q;
    ireq_d = ireq_q;
    if (state_q == S_RUN) begin
      cyc_d  = sat_inc(cyc_q, 1'b1);
      inst_d = sat_inc(inst_q, halt | reg_wr | mem_wr);
      dhit_d = sat_inc(dhit_q, dcache_hit);
      ihit_d = sat_inc(ihit_q, icache_hit);
      dreq_d = sat_inc(dreq_q, dcache_req);
      ireq_d = sat_inc(ireq_q, icache_req);
    end
  end

  always_comb begin
    stat_val = '0;
    case (stat_idx_q)
      3'd0:    stat_val = cyc_q;
      3'd1:    stat_val = inst_q;
      3'd2:    stat_val = dhit_q;
      3'd3:    stat_val = ihit_q;
      3'd4:    stat_val = dreq_q;
      3'd5:    stat_val = ireq_q;
      default: stat_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_q      <= '0;
      inst_q     <= '0;
      dhit_q     <= '0;
      ihit_q     <= '0;
      dreq_q     <= '0;
      ireq_q     <= '0;
      stat_idx_q <= '0;
    end else begin
      cyc_q      <= cyc_d;
      inst_q     <= inst_d;
      dhit_q     <= dhit_d;
      ihit_q     <= ihit_d;
      dreq_q     <= dreq_d;
      ireq_q     <= ireq_d;
      stat_idx_q <= stat_idx_d;
    end
  end
`else
  logic unused_strobes;
  assign unused_strobes = ^{icache_req, icache_hit, dcache_req, dcache_hit};
`endif

  // Next-state, push/pop and occupancy
  always_comb begin
    state_d    = state_q;
    overflow_d = overflow_q;
    push0      = 1'b0;
    push1      = 1'b0;
    pop        = 1'b0;
    rec0       = reg_rec;
    rec1       = mem_rec;
`ifdef TRACE_STATS_EN
    stat_idx_d = stat_idx_q;
`endif
    case (state_q)
      S_RUN: begin
        pop = head_valid & rec_ready;
        // All-or-nothing: free space is judged before this cycle's pop
        if (need > free_slots) begin
          overflow_d = 1'b1;
        end else if (reg_wr) begin
          push0 = 1'b1;
          push1 = mem_rd | mem_wr;
        end else if (mem_rd | mem_wr) begin
          push0 = 1'b1;
          rec0  = mem_rec;
        end
        if (halt) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        pop = head_valid & rec_ready;
`ifdef TRACE_STATS_EN
        if (!head_valid) state_d = S_STATS;
`else
        if (!head_valid) state_d = S_DONE;
`endif
      end
`ifdef TRACE_STATS_EN
      S_STATS: begin
        if (rec_ready) begin
          stat_idx_d = stat_idx_q + 3'd1;
          if (stat_idx_q == 3'd5) state_d = S_DONE;
        end
      end
`endif
      S_DONE: state_d = S_DONE;
      default: state_d = S_RUN;
    endcase
    n_push   = CNT_W'(push0) + CNT_W'(push1);
    count_d  = count_q + n_push - CNT_W'(pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(n_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    full_d   = (CNT_W'(DEPTH) - count_d) < CNT_W'(2);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_RUN;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      full_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      full_q     <= full_d;
    end
  end

  // Record storage; contents are qualified by count_q so no reset is needed
  always_ff @(posedge clk) begin
    if (push0) mem_q[wr_ptr_q]  <= rec0;
    if (push1) mem_q[wr_ptr_p1] <= rec1;
  end

  // Output mux: FIFO head while tracing/draining, statistic record in STATS
  always_comb begin
    rec_valid = 1'b0;
    rec_type  = '0;
    rec_a     = '0;
    rec_b     = '0;
    if ((state_q == S_RUN || state_q == S_DRAIN) && head_valid) begin
      rec_valid = 1'b1;
      rec_type  = head.rtype;
      rec_a     = head.a;
      rec_b     = head.b;
    end
`ifdef TRACE_STATS_EN
    else if (state_q == S_STATS) begin
      rec_valid = 1'b1;
      rec_type  = T_STAT;
      rec_a     = {13'b0, stat_idx_q};
      rec_b     = stat_val;
    end
`endif
  end

  assign trace_full = full_q;
  assign overflow   = overflow_q;
  assign done       = (state_q == S_DONE);

endmodule

// File: doc/trace_emitter.md
# trace_emitter

Synthesizable commit-trace transmitter for the pipelined 16-bit processor. Samples per-cycle retirement events at the writeback/memory boundary: register writes, loads, stores, cache requests/hits and halt. Packs them into typed records, buffers them in a FIFO and sends them over a valid/ready port to an off-core debug sink. After halt it drains the FIFO, emits summary statistic records and raises `done`.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, minimum 4.
- `clk` input 1: single clock, all state on rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `reg_wr` input 1: register file write this cycle.
- `reg_sel` input 3: destination register.
- `reg_data` input 16: register write data.
- `mem_rd` input 1: data memory read this cycle.
- `mem_wr` input 1: data memory write this cycle.
- `mem_addr` input 16: data memory address.
- `mem_rdata` input 16: load data.
- `mem_wdata` input 16: store data.
- `halt` input 1: halt retiring this cycle.
- `icache_req`, `icache_hit`, `dcache_req`, `dcache_hit` input 1 each: cache event strobes.
- `rec_valid` output 1: record available.
- `rec_ready` input 1: sink accepts record.
- `rec_type` output 2: 0 REG, 1 LOAD, 2 STORE, 3 STAT.
- `rec_a` output 16: REG `{13'b0,reg_sel}`; LOAD/STORE `mem_addr`; STAT `{13'b0,stat_id}`.
- `rec_b` output 16: REG `reg_data`; LOAD `mem_rdata`; STORE `mem_wdata`; STAT count.
- `trace_full` output 1: fewer than 2 free entries; pipeline stalls retirement.
- `overflow` output 1: sticky; an event was dropped.
- `done` output 1: all records including stats have been sent.

## Operation
- FSM states RUN → DRAIN → STATS → DONE.
- RUN: each cycle, build up to 2 records in fixed order REG, then LOAD or STORE. `mem_rd` and `mem_wr` both high counts as STORE only. Push them the same cycle.
  - If free entries < records needed, push none, set `overflow`.
  - `halt` high: push that cycle's records, then go to DRAIN.
- DRAIN: ignore all event inputs. Go to STATS the cycle after the FIFO becomes empty.
- STATS: present 6 records directly on the output, stat_id 0..5 = cycles, inst, dcache_hit, icache_hit, dcache_req, icache_req. Index advances on each handshake; after id 5 is accepted, go to DONE.
- DONE: `rec_valid`=0, `done`=1; stays until reset.
- Counters are 16-bit, saturate at 0xFFFF, and increment only in RUN, including the halt cycle:
  - cycles: every RUN cycle.
  - inst: when `halt|reg_wr|mem_wr`.
  - cache counters: on their strobes.
- Record output is the FIFO head in RUN/DRAIN and the stat mux in STATS.

## Timing
- Reset values: `rec_valid`, `rec_type`, `rec_a`, `rec_b`, `trace_full`, `overflow` and `done` are all 0. FIFO is empty, counters are 0, state is RUN.
- Latency: event in cycle N appears on `rec_valid` in cycle N+1 at the earliest (registered FIFO).
- Handshake: pop on `rec_valid&rec_ready`.
  - Record fields are stable while `rec_valid&!rec_ready`.
  - `rec_valid` is never withdrawn without a transfer.
- Simultaneous push and pop is legal. Free-space checks use occupancy before the pop.
- `trace_full` is registered from post-update occupancy, so the pipeline sees it one cycle later. DEPTH ≥ 4 guarantees the stall-cycle events still fit.
- Pointers wrap modulo DEPTH. Occupancy is a separate log2(DEPTH)+1-bit count.
- Reset asserted mid-operation clears everything asynchronously. Records in flight are lost; no partial record is presented.

## Configuration
- `TRACE_STATS_EN` defined: counters and the STATS state are compiled in, as described above.
- Not defined: no counters and no STATS state. DRAIN goes directly to DONE, so exactly the event records are emitted before `done`.

## Test plan
- Single register write, `reg_sel`=3, `reg_data`=0x1234, `rec_ready`=1 → next cycle one REG record: a=0x0003, b=0x1234.
- Load writing r5 with `mem_addr`=0x0040, `mem_rdata`=0xBEEF → REG (5, 0xBEEF), then LOAD (0x0040, 0xBEEF) on consecutive accepted cycles.
- `rec_ready`=0 while issuing 1 store per cycle, DEPTH=8:
  - `trace_full` rises after occupancy reaches 7.
  - A forced further 2-record event sets `overflow` and is not pushed.
  - All 8 stored records are delivered in order after `rec_ready`=1.
- Halt after 3 stores over 10 RUN cycles, with 2 icache hits of 4 requests (`TRACE_STATS_EN`) → 3 STORE records, then STAT records cycles=10, inst=4, dcache_hit=0, icache_hit=2, dcache_req=0, icache_req=4, then `done`=1.
- Same halt scenario without `TRACE_STATS_EN` → 3 STORE records, then `done`=1, no STAT records.
- Reset pulled low during STATS with `rec_ready` toggling → all outputs 0 immediately. After release, state is RUN with an empty FIFO.
